// File: rtl/my_sr_pkg.sv
// Shared constants and state type for the PRBS-8 sequence checker.
// Source recurrence: bit n+8 = bit n+2 ^ bit n+4.
package my_sr_pkg;

  localparam int SR_W  = 8;
  localparam int TAP_A = 2;
  localparam int TAP_B = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } sr_state_e;

endpackage

// File: rtl/my_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module my_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/my_sr_chk.sv
// PRBS-8 (taps 2,4) sequence checker with HUNT/CHECK/LOCKED synchroniser and flywheel.
// Define SR_CHK_ERR_CNT_EN to build the saturating Err_cnt and its Clr input.
module my_sr_chk
  import my_sr_pkg::*;
#(
  parameter int LOCK_LEN  = 16,
  parameter int WIN_LEN   = 16,
  parameter int LOSS_ERRS = 4,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Din,
  input  logic             Valid,
  input  logic             Clr,
  output logic             Locked,
  output logic             Err,
  output logic [CNT_W-1:0] Err_cnt
);

  localparam int FILL_W = $clog2(SR_W + 1);
  localparam int RUN_W  = $clog2(LOCK_LEN + 1);
  localparam int WIN_W  = $clog2(WIN_LEN + 1);
  localparam int LE_W   = $clog2(LOSS_ERRS + 1);

  sr_state_e         state_q, state_d;
  logic [SR_W-1:0]   h_q, h_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [LE_W-1:0]   werr_q, werr_d;
  logic              err_q;
  logic              exp_bit, mismatch, shift_bit, lock_err;

  assign exp_bit  = h_q[TAP_A] ^ h_q[TAP_B];
  assign mismatch = Din ^ exp_bit;
  assign lock_err = Valid && (state_q == LOCKED) && mismatch;

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    fill_d    = fill_q;
    run_d     = run_q;
    win_d     = win_q;
    werr_d    = werr_q;
    shift_bit = Din;
    if (Valid) begin
      case (state_q)
        HUNT: begin
          if (fill_q == FILL_W'(SR_W - 1)) begin
            state_d = CHECK;
            fill_d  = '0;
            run_d   = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            state_d = HUNT;
            fill_d  = '0;
          end else if (run_q == RUN_W'(LOCK_LEN - 1)) begin
            state_d = LOCKED;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            run_d = run_q + 1'b1;
          end
        end
        LOCKED: begin
          // Flywheel: feed the prediction back so a corrupted bit cannot poison H.
          shift_bit = exp_bit;
          if (mismatch && (werr_q == LE_W'(LOSS_ERRS - 1))) begin
            state_d = HUNT;
            fill_d  = '0;
          end else if (win_q == WIN_W'(WIN_LEN - 1)) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 1'b1;
            werr_d = werr_q + LE_W'(mismatch);
          end
        end
        default: state_d = HUNT;
      endcase
      h_d = {shift_bit, h_q[SR_W-1:1]};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= HUNT;
      h_q     <= '0;
      fill_q  <= '0;
      run_q   <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      fill_q  <= fill_d;
      run_q   <= run_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      err_q   <= lock_err;
    end
  end

  assign Locked = (state_q == LOCKED);
  assign Err    = err_q;

`ifdef SR_CHK_ERR_CNT_EN
  // Counting the detection itself keeps Err_cnt aligned with the Err pulse.
  my_sat_cnt #(
    .WIDTH(CNT_W)
  ) u_err_cnt (
    .clk(CLK),
    .rst(RST),
    .inc(lock_err),
    .clr(Clr),
    .cnt(Err_cnt)
  );
`else
  logic unused_clr;
  assign unused_clr = Clr;
  assign Err_cnt    = '0;
`endif

endmodule

// File: tb/tb_my_sr_chk.sv
// Self-checking bench for my_sr_chk: vector table, directed lock/loss sequences, random stream vs model.
module tb_my_sr_chk;

  localparam int LOCK_LEN  = 16;
  localparam int WIN_LEN   = 16;
  localparam int LOSS_ERRS = 4;
  localparam int M_HUNT = 0, M_CHECK = 1, M_LOCK = 2;
`ifdef SR_CHK_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, Din, Valid, Clr;
  logic        Locked, Err, Locked4, Err4;
  logic [15:0] Err_cnt;
  logic [3:0]  Err_cnt4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  my_sr_chk dut (
    .CLK(CLK), .RST(RST), .Din(Din), .Valid(Valid), .Clr(Clr),
    .Locked(Locked), .Err(Err), .Err_cnt(Err_cnt)
  );

  my_sr_chk #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .Din(Din), .Valid(Valid), .Clr(Clr),
    .Locked(Locked4), .Err(Err4), .Err_cnt(Err_cnt4)
  );

  // Source generator: LSB out, bit n+8 = bit n+2 ^ bit n+4 enters at the top.
  logic [7:0] g;
  task automatic gen_bit(output bit b);
    b = g[0];
    g = {g[2] ^ g[4], g[7:1]};
  endtask

  // Reference model: last 8 accepted bits (oldest first) plus mode and window bookkeeping.
  bit mh[$];
  int mmode, mfill, mrun, mwpos, mwerr, mtotal;
  bit m_err;

  task automatic model_reset();
    mh = {};
    for (int i = 0; i < 8; i++) mh.push_back(1'b0);
    mmode = M_HUNT; mfill = 0; mrun = 0; mwpos = 0; mwerr = 0; mtotal = 0;
    m_err = 1'b0;
  endtask

  task automatic shift_in(input bit b);
    mh.push_back(b);
    void'(mh.pop_front());
  endtask

  task automatic model_step(input bit d, input bit v, input bit c);
    bit pred;
    m_err = 1'b0;
    if (v) begin
      pred = mh[2] ^ mh[4];
      if (mmode == M_HUNT) begin
        shift_in(d);
        mfill++;
        if (mfill == 8) begin mmode = M_CHECK; mrun = 0; end
      end else if (mmode == M_CHECK) begin
        shift_in(d);
        if (d != pred) begin
          mmode = M_HUNT; mfill = 0;
        end else begin
          mrun++;
          if (mrun == LOCK_LEN) begin mmode = M_LOCK; mwpos = 0; mwerr = 0; end
        end
      end else begin
        shift_in(pred);
        if (d != pred) begin m_err = 1'b1; mwerr++; end
        mwpos++;
        if (mwerr == LOSS_ERRS) begin
          mmode = M_HUNT; mfill = 0;
        end else if (mwpos == WIN_LEN) begin
          mwpos = 0; mwerr = 0;
        end
      end
    end
    if (c) mtotal = 0;
    else if (m_err) mtotal++;
  endtask

  task automatic check_all(input string tag);
    logic [23:0] act, exp;
    int e16, e4;
    e16 = CNT_EN ? ((mtotal > 65535) ? 65535 : mtotal) : 0;
    e4  = CNT_EN ? ((mtotal > 15) ? 15 : mtotal) : 0;
    act = {Locked, Err, Err_cnt, Locked4, Err4, Err_cnt4};
    exp = {mmode == M_LOCK, m_err, 16'(e16), mmode == M_LOCK, m_err, 4'(e4)};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got L=%0b E=%0b C=%0d L4=%0b E4=%0b C4=%0d want L=%0b E=%0b C=%0d C4=%0d",
               tag, $time, Locked, Err, Err_cnt, Locked4, Err4, Err_cnt4,
               mmode == M_LOCK, m_err, e16, e4);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit d, input bit v, input bit c, input string tag);
    @(negedge CLK);
    Din = d; Valid = v; Clr = c;
    @(posedge CLK);
    #1;
    model_step(d, v, c);
    check_all(tag);
  endtask

  // Reset asserted asynchronously mid-cycle; released just after an edge.
  task automatic do_reset();
    RST = 1'b1; Din = 1'b0; Valid = 1'b0; Clr = 1'b0;
    #1;
    model_reset();
    check_all("reset_async");
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic send(input bit inv, input string tag);
    bit b;
    gen_bit(b);
    cyc(b ^ inv, 1'b1, 1'b0, tag);
  endtask

  task automatic count_to_lock(input int period, input int max_cyc, output int nvalid);
    int nv;
    bit b;
    nv = 0;
    nvalid = -1;
    for (int k = 0; k < max_cyc; k++) begin
      if (k % period == 0) begin
        gen_bit(b);
        cyc(b, 1'b1, 1'b0, "to_lock");
        nv++;
      end else begin
        cyc(1'($urandom), 1'b0, 1'b0, "to_lock_gap");
      end
      if (Locked) begin nvalid = nv; break; end
    end
  endtask

  typedef struct {
    bit din; bit valid; bit clr;
    bit exp_locked; bit exp_err; int exp_cnt;
  } vec_t;
  vec_t tbl[36];

  initial begin
    int nv, seen;
    bit hi_rate;
    logic [21:0] act, exp;

    RST = 1'b1; Din = 1'b0; Valid = 1'b0; Clr = 1'b0; g = 8'hA5;
    model_reset();
    #1;
    check_all("power_on_reset");

    // All-zero stream locks after 24 bits and is never an error; then errors, gaps, Clr.
    for (int i = 0; i < 30; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, (i >= 23), 1'b0, 0};
    tbl[30] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[31] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[32] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[33] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    tbl[34] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[35] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    do_reset();
    for (int i = 0; i < 36; i++) begin
      cyc(tbl[i].din, tbl[i].valid, tbl[i].clr, "table");
      act = {Locked, Err, Err_cnt, Err_cnt4};
      exp = {tbl[i].exp_locked, tbl[i].exp_err,
             16'(CNT_EN ? tbl[i].exp_cnt : 0), 4'(CNT_EN ? tbl[i].exp_cnt : 0)};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL table[%0d] got L=%0b E=%0b C=%0d C4=%0d want L=%0b E=%0b C=%0d",
                 i, Locked, Err, Err_cnt, Err_cnt4, tbl[i].exp_locked, tbl[i].exp_err,
                 CNT_EN ? tbl[i].exp_cnt : 0);
      end
      $display("vec %0d din=%0b valid=%0b clr=%0b -> L=%0b E=%0b C=%0d",
               i, tbl[i].din, tbl[i].valid, tbl[i].clr, Locked, Err, Err_cnt);
    end

    // Seed A5, continuous Valid: lock at 24, then a single error on bit 40.
    g = 8'hA5;
    do_reset();
    count_to_lock(1, 200, nv);
    chk("lock_a5_bits", nv, 24);
    for (int i = 25; i < 40; i++) send(1'b0, "clean_a5");
    send(1'b1, "bit40");
    chk("bit40_err", int'(Err), 1);
    chk("bit40_locked", int'(Locked), 1);
    chk("bit40_cnt", int'(Err_cnt), CNT_EN ? 1 : 0);
    send(1'b0, "after40");
    chk("bit40_err_one_cycle", int'(Err), 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      send(1'b0, "after40_run");
      if (Err) seen++;
    end
    chk("no_err_after_flywheel", seen, 0);
    $display("seq single_error: lock=%0d cnt=%0d", nv, Err_cnt);

    // Reset while an Err pulse is high: everything drops at once, no late pulse.
    send(1'b1, "pre_reset_err");
    chk("err_before_reset", int'(Err), 1);
    do_reset();
    count_to_lock(1, 200, nv);
    chk("relock_after_reset", nv, 24);
    chk("cnt_after_reset", int'(Err_cnt), 0);
    $display("seq reset_mid_locked: relock=%0d", nv);

    // Four errors in one window: loss on the 4th, relock after 24 clean bits.
    for (int p = 0; p < 12; p++) send(p == 1 || p == 4 || p == 8 || p == 11, "loss_window");
    chk("loss_locked", int'(Locked), 0);
    chk("loss_err", int'(Err), 1);
    chk("loss_cnt", int'(Err_cnt), CNT_EN ? 4 : 0);
    count_to_lock(1, 200, nv);
    chk("relock_after_loss", nv, 24);
    $display("seq loss_of_lock: relock=%0d cnt=%0d", nv, Err_cnt);

    // Seed 3C with Valid pattern 1,0,0: lock counts valid bits only.
    g = 8'h3C;
    do_reset();
    count_to_lock(3, 300, nv);
    chk("lock_3c_gapped", nv, 24);
    $display("seq gapped_valid: lock=%0d", nv);

    // Two errors per window for ten windows: 4-bit counter saturates; Clr beats an error.
    g = 8'h5A;
    do_reset();
    count_to_lock(1, 200, nv);
    chk("lock_5a_bits", nv, 24);
    for (int w = 0; w < 10; w++)
      for (int p = 0; p < 16; p++) send(p == 3 || p == 10, "sat_windows");
    chk("sat_locked", int'(Locked), 1);
    chk("sat_cnt4", int'(Err_cnt4), CNT_EN ? 15 : 0);
    chk("sat_cnt16", int'(Err_cnt), CNT_EN ? 20 : 0);
    gen_bit(hi_rate);
    cyc(~hi_rate, 1'b1, 1'b1, "clr_with_err");
    chk("clr_err_pulse", int'(Err), 1);
    chk("clr_priority_cnt16", int'(Err_cnt), 0);
    chk("clr_priority_cnt4", int'(Err_cnt4), 0);
    $display("seq saturation: cnt4 cleared to %0d", Err_cnt4);

    // Random stream with alternating low/high error rates, random Valid, Clr and resets.
    g = 8'($urandom_range(1, 255));
    do_reset();
    hi_rate = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      bit b, v, c, inv;
      if (k % 500 == 0) begin
        hi_rate = ~hi_rate;
        $display("rand phase %0d hi_rate=%0b compared=%0d", k / 500, hi_rate, n_cmp);
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      v = ($urandom % 4) != 0;
      c = ($urandom % 64) == 0;
      if (v) begin
        gen_bit(b);
        inv = hi_rate ? (($urandom % 6) == 0) : (($urandom % 40) == 0);
        cyc(b ^ inv, 1'b1, c, "random");
      end else begin
        cyc(1'($urandom), 1'b0, c, "random_gap");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/my_sr_chk.md
MY_SR_CHK -- requirements
Module: my_sr_chk

Interface
REQ-001 SHALL have parameter LOCK_LEN, default 16: consecutive correct predictions needed in CHECK before entering LOCKED.
REQ-002 SHALL have parameter WIN_LEN, default 16: length of the loss-of-lock observation window, in valid bits.
REQ-003 SHALL have parameter LOSS_ERRS, default 4: number of errors within one window that forces loss of lock.
REQ-004 SHALL have parameter CNT_W, default 16: width of the error counter.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port Din, input, 1 bit: serial bit from an 8-bit shift-register PRBS source (taps 2,4, shift right, LSB out).
REQ-008 SHALL have port Valid, input, 1 bit: qualifies Din; the block holds its state in cycles where Valid=0.
REQ-009 SHALL have port Clr, input, 1 bit: synchronous clear of Err_cnt.
REQ-010 SHALL have port Locked, output, 1 bit: high while the state is LOCKED.
REQ-011 SHALL have port Err, output, 1 bit: one-cycle pulse when a mismatch is detected in LOCKED.
REQ-012 SHALL have port Err_cnt, output, CNT_W bits: saturating count of LOCKED errors.

Function
REQ-013 SHALL keep an 8-bit history register H; each valid bit shifts H right, with the new bit entering H[7].
REQ-014 SHALL compute the expected bit as H[2]^H[4], which predicts source bit n+8 from bits n+2 and n+4.
REQ-015 SHALL implement state HUNT: shift in Din, count fill bits 0..8, and go to CHECK once 8 bits have been shifted in.
REQ-016 SHALL implement state CHECK: compare Din with the expected bit and shift in Din; a mismatch returns the state to HUNT with the fill count cleared; LOCK_LEN consecutive matches go to LOCKED.
REQ-017 SHALL implement state LOCKED: shift in the expected bit, not Din (flywheel), so that single bit errors do not propagate.
REQ-018 SHALL, in LOCKED, register a mismatch: Err goes high on the cycle after the valid bit and stays high for one cycle only.
REQ-019 SHALL run a window counter in LOCKED that counts valid bits 0..WIN_LEN-1, then wraps and clears the window error count.
REQ-020 SHALL go to HUNT when the window error count reaches LOSS_ERRS; Locked falls in that same cycle and H is retained.
REQ-021 SHALL give LOSS_ERRS priority over a window wrap when both occur on the same bit.
REQ-022 SHALL set Locked high in the cycle after the LOCK_LEN-th matching bit, i.e. 8+LOCK_LEN valid bits after reset when the stream is error-free.
REQ-023 SHALL increment Err_cnt by 1 per Err event and saturate at all-ones.
REQ-024 SHALL give Clr priority over an increment in the same cycle, leaving Err_cnt at 0.
REQ-025 SHALL treat an all-zero stream as a valid sequence (predicted 0); it is not flagged as an error.

Reset
REQ-026 SHALL, while RST=1 and regardless of CLK, set state=HUNT, H=8'h00, all counters=0, Locked=0, Err=0, Err_cnt=0.
REQ-027 SHALL abort any operation in progress when RST is asserted mid-LOCKED; no Err pulse is produced afterwards.

Configuration
REQ-028 SHALL, when SR_CHK_ERR_CNT_EN is defined, implement Err_cnt and Clr as specified above.
REQ-029 SHALL, when SR_CHK_ERR_CNT_EN is undefined, tie Err_cnt to 0, ignore Clr, and leave Err and Locked behaviour unchanged.

Structure
REQ-030 SHALL take the following from shared package my_sr_pkg: SR_W=8, tap constants TAP_A=2 and TAP_B=4, and the state enum type {HUNT, CHECK, LOCKED}.
REQ-031 SHALL implement the saturating counter as sub-module my_sat_cnt (parameter width; inputs inc and clr).
REQ-032 SHALL keep the state machine and history register H in my_sr_chk itself.

Verification
REQ-033 SHALL be verified with this scenario: generator with SEED=8'hA5 drives Din, Valid=1 continuously -> Locked rises exactly 24 cycles after RST deasserts, Err stays 0, Err_cnt stays 0.
REQ-034 SHALL be verified with this scenario: after lock, invert the 40th bit -> one Err pulse, Err_cnt=1, Locked stays 1, later bits produce no Err.
REQ-035 SHALL be verified with this scenario: after lock, invert 4 bits within one 16-bit window -> Locked=0 on the 4th error, Err_cnt=4, relock after a further 24 clean bits.
REQ-036 SHALL be verified with this scenario: Valid toggling 1,0,0,1,... with SEED=8'h3C -> lock occurs after 24 valid bits, regardless of the gaps.
REQ-037 SHALL be verified with this scenario: CNT_W=4, invert 2 bits per window for 10 windows -> Err_cnt=15 (saturated); Clr and an error in the same cycle -> Err_cnt=0.
REQ-038 SHALL be verified with this scenario: assert RST mid-LOCKED -> all outputs 0 immediately; with SR_CHK_ERR_CNT_EN undefined, Err_cnt stays 0 throughout.
